// File: rtl/memarb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package memarb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arbState_t;

  localparam int unsigned MAX_WAIT_DEFAULT = 15;

  // Width needed to hold wait counts 0 .. maxWait-1.
  function automatic int unsigned ctrWidth(input int unsigned maxWait);
    return (maxWait < 2) ? 1 : $clog2(maxWait);
  endfunction

endpackage

// File: rtl/memarb_wait_ctr.sv
// Wait counter for an outstanding memory request; flags the timeout cycle.
module memarb_wait_ctr
  import memarb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic timeout
);

  localparam int unsigned CW = ctrWidth(MAX_WAIT);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  logic [CW-1:0] count;

  // Count busy cycles without acknowledge; cleared when a new grant is made.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + CW'(1);
  end

  // The MAX_WAIT-th unacknowledged busy cycle is the last one mem_req is held.
  assign timeout = inc && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single shared memory.
// Optional MEMARB_PERF_EN adds perf_ifetch/perf_data/perf_wait counters.
module mem_arbiter
  import memarb_pkg::*;
#(
  parameter int unsigned DATA_FIRST = 1,
  parameter int unsigned MAX_WAIT   = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        err
`ifdef MEMARB_PERF_EN
  ,
  output logic [31:0] perf_ifetch,
  output logic [31:0] perf_data,
  output logic [31:0] perf_wait
`endif
);

  arbState_t state, stateNext;
  logic ifCand, dCand, grantI, grantD, grant;
  logic busy, ack, timeout, done, ownerReq, weReg;

  // A port in its own completion cycle still shows req high; it is not a new request.
  assign ifCand = if_req & ~if_ready;
  assign dCand  = d_req & ~d_ready;
  assign busy   = (state != IDLE);
  assign ack    = busy & mem_ack;
  assign done   = ack | timeout;
  assign grant  = grantI | grantD;

  assign mem_req = busy;
  assign mem_we  = busy & weReg;
  assign stall   = (if_req & ~if_ready) | (d_req & ~d_ready);

  memarb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) uWaitCtr (
    .clk    (clk),
    .reset  (reset),
    .clr    (grant),
    .inc    (busy & ~mem_ack),
    .timeout(timeout)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next state, fixed-priority grant and current owner's request.
  always_comb begin
    stateNext = state;
    grantI    = 1'b0;
    grantD    = 1'b0;
    ownerReq  = 1'b0;
    case (state)
      IDLE: begin
        if (DATA_FIRST != 0) begin
          grantD = dCand;
          grantI = ifCand & ~dCand;
        end else begin
          grantI = ifCand;
          grantD = dCand & ~ifCand;
        end
        if (grantD)      stateNext = BUSY_D;
        else if (grantI) stateNext = BUSY_I;
      end
      BUSY_I: begin
        ownerReq = if_req;
        if (done) stateNext = IDLE;
      end
      BUSY_D: begin
        ownerReq = d_req;
        if (done) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Latch the winning command at grant time; held for the whole transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      weReg     <= 1'b0;
    end else if (grant) begin
      mem_addr <= grantD ? d_addr : if_addr;
      weReg    <= grantD & d_we;
      if (grantD) mem_wdata <= d_wdata;
    end
  end

  // Completion: one-cycle ready/err pulses; abandoned transactions complete silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      err      <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      err      <= 1'b0;
      if (done && ownerReq) begin
        err <= timeout;
        if (state == BUSY_I) begin
          if_ready <= 1'b1;
          if_rdata <= ack ? mem_rdata : '0;
        end else begin
          d_ready <= 1'b1;
          if (!weReg) d_rdata <= ack ? mem_rdata : '0;
        end
      end
    end
  end

`ifdef MEMARB_PERF_EN
  // Wrapping performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_ifetch <= '0;
      perf_data   <= '0;
      perf_wait   <= '0;
    end else begin
      if (if_ready) perf_ifetch <= perf_ifetch + 32'd1;
      if (d_ready)  perf_data   <= perf_data + 32'd1;
      if (stall)    perf_wait   <= perf_wait + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_FIRST, default 1: 1 gives the data port fixed priority over fetch; 0 gives fetch priority.
REQ-002 SHALL have parameter MAX_WAIT, default 15: maximum cycles mem_req may stay high without mem_ack before timeout.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port if_req, input, 1: fetch request, held until if_ready.
REQ-006 SHALL have port if_addr, input, 32: fetch address.
REQ-007 SHALL have port if_rdata, output, 32: fetch read data.
REQ-008 SHALL have port if_ready, output, 1: one-cycle completion pulse for fetch.
REQ-009 SHALL have port d_req, input, 1: data request, held until d_ready.
REQ-010 SHALL have port d_we, input, 1: data write enable.
REQ-011 SHALL have port d_addr, input, 32: data address.
REQ-012 SHALL have port d_wdata, input, 32: data write value.
REQ-013 SHALL have port d_rdata, output, 32: data read value.
REQ-014 SHALL have port d_ready, output, 1: one-cycle completion pulse for data.
REQ-015 SHALL have port mem_req, output, 1: request to the shared memory.
REQ-016 SHALL have port mem_we, output, 1: write to the shared memory.
REQ-017 SHALL have port mem_addr, output, 32: shared memory address.
REQ-018 SHALL have port mem_wdata, output, 32: shared memory write data.
REQ-019 SHALL have port mem_rdata, input, 32: shared memory read data.
REQ-020 SHALL have port mem_ack, input, 1: shared memory completion.
REQ-021 SHALL have port stall, output, 1: pipeline hold.
REQ-022 SHALL have port err, output, 1: one-cycle timeout pulse.

Function
REQ-023 SHALL implement FSM states IDLE, BUSY_I and BUSY_D.
REQ-024 In IDLE, SHALL grant at most one requester per cycle.
- Both requesting: priority per DATA_FIRST.
- On grant: register addr, we and wdata; enter BUSY_x next cycle.
REQ-025 In BUSY_x, SHALL drive mem_req=1 and the registered command from the first BUSY cycle until mem_ack.
- Latency: request sampled in cycle 0; mem_req asserted in cycle 1.
REQ-026 On mem_ack in BUSY_x, SHALL deliver the completion in the next cycle.
- Capture mem_rdata into x_rdata (held until the next completion for that port).
- Pulse x_ready=1 for exactly one cycle.
- Return to IDLE.
- A new grant is possible in that same IDLE cycle.
REQ-027 For writes, d_rdata SHALL be left unchanged.
REQ-028 mem_ack in IDLE SHALL be ignored.
REQ-029 The wait counter SHALL clear on grant and increment each BUSY cycle without mem_ack.
REQ-030 On reaching MAX_WAIT, SHALL handle the timeout as follows.
- Drop mem_req.
- Pulse err and x_ready together.
- Set x_rdata=0.
- Return to IDLE.
REQ-031 stall SHALL equal (if_req & ~if_ready) | (d_req & ~d_ready), combinational.
REQ-032 A requester deasserting req while BUSY SHALL NOT abort the transaction; its completion SHALL be discarded silently.

Reset
REQ-033 Asserting reset SHALL immediately force the following, including mid-transaction.
- FSM to IDLE.
- mem_req, mem_we, if_ready, d_ready and err to 0.
- mem_addr, mem_wdata, if_rdata, d_rdata and the wait counter to 0.
REQ-034 The first grant SHALL occur no earlier than the first rising edge after reset deasserts.

Configuration
REQ-035 With MEMARB_PERF_EN defined, SHALL add outputs perf_ifetch, perf_data and perf_wait (32 bits each, wrapping, reset to 0).
- perf_ifetch counts fetch completions.
- perf_data counts data completions.
- perf_wait counts cycles with stall=1.
REQ-036 Without MEMARB_PERF_EN, those ports and their counters SHALL be absent.

Structure
REQ-037 SHALL place the FSM state enum and the default MAX_WAIT constant in shared package memarb_pkg.
REQ-038 SHALL implement the wait counter and timeout compare as sub-module memarb_wait_ctr.

Verification
REQ-039 SHALL cover: if_req, addr 0x100; mem_ack in cycle 2 with rdata 0xDEADBEEF -> mem_req in cycles 1-2, if_ready and if_rdata=0xDEADBEEF in cycle 3.
REQ-040 SHALL cover: simultaneous if_req and d_req, DATA_FIRST=1 -> data served first, then fetch granted in data's completion cycle; stall=1 throughout.
REQ-041 SHALL cover: d_we=1, addr 0x200, wdata 0x55; ack in cycle 1 -> mem_we=1, mem_wdata=0x55, d_ready in cycle 2, d_rdata unchanged.
REQ-042 SHALL cover: no mem_ack, MAX_WAIT=15 -> err and x_ready pulse together, x_rdata=0, FSM back in IDLE.
REQ-043 SHALL cover: reset asserted while BUSY_D -> mem_req=0 asynchronously, no d_ready; after release, a pending if_req is granted normally.
REQ-044 SHALL cover: with MEMARB_PERF_EN, 3 fetches and 2 data accesses -> perf_ifetch=3, perf_data=2.
